// File: rtl/shrimp_regfile_write_arbiter.sv
// shrimp_regfile_write_arbiter
// Shares the single regfile write port between the ALU and the memory load
// unit. It uses a round-robin grant and a registered write port. A busy
// scoreboard tracks registers that have a pending load writeback.
//
// Handshake: a source holds valid (with addr/val stable) until it sees ready.
// A transfer happens at the rising edge where valid && ready are both high.
// Ready is a pure function of the valids, the registered arbitration/busy
// state and reset_n. It never rises without its valid.
module shrimp_regfile_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_val,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_val,
    output logic                  mem_ready,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic                  rsv_ready,
    output logic [ADDR_WIDTH-1:0] reg_w_addr,
    output logic [DATA_WIDTH-1:0] reg_w_val,
    output logic                  reg_w_enable,
    output logic [NUM_REGS-1:0]   busy
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    // Source that won the most recent accepted handshake; breaks ties.
    src_t last_grant;

    logic                grant_alu;
    logic                grant_mem;
    logic                rsv_accept;
    logic [NUM_REGS-1:0] busy_next;

    // Round-robin grant. On a tie, the source not granted last wins. Reset masks all grants.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (reset_n) begin
            if (alu_valid && mem_valid) begin
                if (last_grant == SRC_MEM) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_mem = 1'b1;
                end
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // A reservation only looks at registered busy. A bit being cleared this cycle still blocks.
    assign rsv_ready  = reset_n && !busy[rsv_addr];
    assign rsv_accept = rsv_valid && rsv_ready;

    // Scoreboard next state: commit clears, reservation sets; set applied last so it wins.
    always_comb begin
        busy_next = busy;
        if (reg_w_enable) begin
            busy_next[reg_w_addr] = 1'b0;
        end
        if (rsv_accept) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Registered write port and arbitration history; reset drops any in-flight write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            reg_w_enable <= 1'b0;
            reg_w_addr   <= '0;
            reg_w_val    <= '0;
            last_grant   <= SRC_MEM;
        end else if (grant_alu) begin
            reg_w_enable <= 1'b1;
            reg_w_addr   <= alu_addr;
            reg_w_val    <= alu_val;
            last_grant   <= SRC_ALU;
        end else if (grant_mem) begin
            reg_w_enable <= 1'b1;
            reg_w_addr   <= mem_addr;
            reg_w_val    <= mem_val;
            last_grant   <= SRC_MEM;
        end else begin
            reg_w_enable <= 1'b0;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_shrimp_regfile_write_arbiter.sv
// Directed testbench for shrimp_regfile_write_arbiter.
// Inputs change 1ns after the rising edge. Outputs are sampled there too,
// away from the active edge. A small regfile model captures commits.
module tb_shrimp_regfile_write_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_val;
    logic          alu_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_val;
    logic          mem_ready;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic          rsv_ready;
    logic [AW-1:0] reg_w_addr;
    logic [DW-1:0] reg_w_val;
    logic          reg_w_enable;
    logic [NR-1:0] busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Regfile model. It captures a commit at the end of the cycle, but not while reset is held.
    logic [DW-1:0] rf [NR] = '{default: '0};

    // Expected write-port contents for the contention burst.
    logic [AW+DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && reg_w_enable) rf[reg_w_addr] <= reg_w_val;
    end

    shrimp_regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_val      (alu_val),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_val      (mem_val),
        .mem_ready    (mem_ready),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .rsv_ready    (rsv_ready),
        .reg_w_addr   (reg_w_addr),
        .reg_w_val    (reg_w_val),
        .reg_w_enable (reg_w_enable),
        .busy         (busy)
    );

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        alu_valid = v;
        alu_addr  = a;
        alu_val   = d;
    endtask

    task automatic set_mem(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_val   = d;
    endtask

    task automatic set_rsv(input logic v, input logic [AW-1:0] a);
        rsv_valid = v;
        rsv_addr  = a;
    endtask

    // Table for the contention burst: expected grant per cycle (1 = ALU).
    logic [3:0] burst_alu = 4'b0101;

    initial begin
        logic [AW+DW-1:0] e;
        reset_n = 1'b0;
        set_alu(1'b1, 4'h0, 16'h0);
        set_mem(1'b0, 4'h0, 16'h0);
        set_rsv(1'b0, 4'h0);

        // ---- reset: two edges low with alu_valid high ----
        step();
        step();
        check_eq("rst_wen",   {31'b0, reg_w_enable}, 32'd0);
        check_eq("rst_waddr", {28'b0, reg_w_addr},   32'd0);
        check_eq("rst_wval",  {16'b0, reg_w_val},    32'd0);
        check_eq("rst_busy",  {16'b0, busy},         32'h0000);
        check_eq("rst_alu_rdy", {31'b0, alu_ready},  32'd0);
        check_eq("rst_mem_rdy", {31'b0, mem_ready},  32'd0);
        check_eq("rst_rsv_rdy", {31'b0, rsv_ready},  32'd0);
        reset_n = 1'b1;
        #1;
        check_eq("rel_alu_rdy", {31'b0, alu_ready},  32'd1);
        set_alu(1'b0, 4'h0, 16'h0);

        // ---- single ALU write to r3 ----
        #1;
        set_alu(1'b1, 4'h3, 16'd120);
        #1;
        check_eq("sw_alu_rdy", {31'b0, alu_ready}, 32'd1);
        step();
        set_alu(1'b0, 4'h0, 16'h0);
        check_eq("sw_wen",   {31'b0, reg_w_enable}, 32'd1);
        check_eq("sw_waddr", {28'b0, reg_w_addr},   32'd3);
        check_eq("sw_wval",  {16'b0, reg_w_val},    32'd120);
        step();
        check_eq("sw_wen_off", {31'b0, reg_w_enable}, 32'd0);
        check_eq("sw_rf3",     {16'b0, rf[3]},        32'd120);
        check_eq("sw_busy",    {16'b0, busy},         32'h0000);

        // ---- single MEM write to r4; last grant becomes MEM ----
        set_mem(1'b1, 4'h4, 16'd44);
        #1;
        check_eq("mw_mem_rdy", {31'b0, mem_ready}, 32'd1);
        step();
        set_mem(1'b0, 4'h0, 16'h0);
        check_eq("mw_waddr", {28'b0, reg_w_addr}, 32'd4);
        check_eq("mw_wval",  {16'b0, reg_w_val},  32'd44);
        step();

        // ---- contention: both valid four cycles -> ALU, MEM, ALU, MEM ----
        set_alu(1'b1, 4'h1, 16'd10);
        set_mem(1'b1, 4'h2, 16'd20);
        for (int k = 0; k < 4; k++) begin
            if (burst_alu[k]) exp_q.push_back({4'h1, 16'd10});
            else              exp_q.push_back({4'h2, 16'd20});
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("ct_alu_rdy%0d", k), {31'b0, alu_ready}, {31'b0, burst_alu[k]});
            check_eq($sformatf("ct_mem_rdy%0d", k), {31'b0, mem_ready}, {31'b0, ~burst_alu[k]});
            step();
            e = exp_q.pop_front();
            check_eq($sformatf("ct_wen%0d", k),   {31'b0, reg_w_enable}, 32'd1);
            check_eq($sformatf("ct_waddr%0d", k), {28'b0, reg_w_addr},   {28'b0, e[AW+DW-1:DW]});
            check_eq($sformatf("ct_wval%0d", k),  {16'b0, reg_w_val},    {16'b0, e[DW-1:0]});
        end
        set_alu(1'b0, 4'h0, 16'h0);
        set_mem(1'b0, 4'h0, 16'h0);
        step();
        check_eq("ct_wen_off", {31'b0, reg_w_enable}, 32'd0);
        check_eq("ct_rf1", {16'b0, rf[1]}, 32'd10);
        check_eq("ct_rf2", {16'b0, rf[2]}, 32'd20);

        // ---- scoreboard round trip on r5 ----
        set_rsv(1'b1, 4'h5);
        #1;
        check_eq("sb_rsv_rdy", {31'b0, rsv_ready}, 32'd1);
        step();
        set_rsv(1'b0, 4'h0);
        check_eq("sb_busy_set", {16'b0, busy}, 32'h0020);
        set_rsv(1'b1, 4'h5);
        #1;
        check_eq("sb_rsv_again", {31'b0, rsv_ready}, 32'd0);
        step();
        set_rsv(1'b0, 4'h5);
        check_eq("sb_busy_hold", {16'b0, busy}, 32'h0020);
        set_mem(1'b1, 4'h5, 16'd55);
        step();
        set_mem(1'b0, 4'h0, 16'h0);
        check_eq("sb_commit_busy", {16'b0, busy},      32'h0020);
        check_eq("sb_commit_rdy",  {31'b0, rsv_ready}, 32'd0);
        step();
        check_eq("sb_busy_clr", {16'b0, busy},      32'h0000);
        check_eq("sb_rdy_back", {31'b0, rsv_ready}, 32'd1);
        check_eq("sb_rf5",      {16'b0, rf[5]},     32'd55);

        // ---- simultaneous set/clear on r7: set wins ----
        set_alu(1'b1, 4'h7, 16'd77);
        step();
        set_alu(1'b0, 4'h0, 16'h0);
        set_rsv(1'b1, 4'h7);
        #1;
        check_eq("sc_wen",     {31'b0, reg_w_enable}, 32'd1);
        check_eq("sc_rsv_rdy", {31'b0, rsv_ready},    32'd1);
        step();
        set_rsv(1'b0, 4'h0);
        check_eq("sc_busy7", {16'b0, busy}, 32'h0080);
        // A second commit clears it again.
        set_alu(1'b1, 4'h7, 16'd78);
        step();
        set_alu(1'b0, 4'h0, 16'h0);
        step();
        check_eq("sc_busy_clr", {16'b0, busy}, 32'h0000);

        // ---- reset mid-operation ----
        set_rsv(1'b1, 4'h2);
        step();
        set_rsv(1'b0, 4'h0);
        check_eq("rm_busy_pre", {16'b0, busy}, 32'h0004);
        set_alu(1'b1, 4'h9, 16'd99);
        step();
        set_alu(1'b0, 4'h0, 16'h0);
        reset_n = 1'b0;
        #1;
        check_eq("rm_alu_rdy", {31'b0, alu_ready}, 32'd0);
        check_eq("rm_rsv_rdy", {31'b0, rsv_ready}, 32'd0);
        step();
        check_eq("rm_wen",  {31'b0, reg_w_enable}, 32'd0);
        check_eq("rm_busy", {16'b0, busy},         32'h0000);
        check_eq("rm_rf9",  {16'b0, rf[9]},        32'd0);
        reset_n = 1'b1;
        step();
        check_eq("rm_wen_after", {31'b0, reg_w_enable}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/shrimp_regfile_write_arbiter.md
# shrimp_regfile_write_arbiter

Shares the single write port of the shrimp register file between two writeback sources: the ALU and the memory load unit. Each source issues writes over a valid/ready handshake. A round-robin grant picks one write per cycle and drives it onto the regfile write port from registers. The block also holds a busy scoreboard: the decoder reserves a destination register when it issues a load, and the matching writeback commit releases it.

## Interface
Parameters:
- DATA_WIDTH, 16, register value width
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU write request
- alu_addr  in  ADDR_WIDTH  ALU destination register
- alu_val  in  DATA_WIDTH  ALU write value
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  memory-load write request
- mem_addr  in  ADDR_WIDTH  load destination register
- mem_val  in  DATA_WIDTH  load write value
- mem_ready  out  1  load request accepted this cycle
- rsv_valid  in  1  decoder reserves a register
- rsv_addr  in  ADDR_WIDTH  register to reserve
- rsv_ready  out  1  reservation accepted (target not busy)
- reg_w_addr  out  ADDR_WIDTH  to regfile write address
- reg_w_val  out  DATA_WIDTH  to regfile write value
- reg_w_enable  out  1  to regfile write enable
- busy  out  NUM_REGS  scoreboard; bit i = register i has a pending reserved write

## Operation
- Grant (combinational):
  - Only alu_valid: grant ALU.
  - Only mem_valid: grant MEM.
  - Both valid: grant the source that was not granted last.
  - Neither valid: no grant.
- alu_ready / mem_ready = grant to that source. At most one is high; a ready never rises without its valid. The block accepts one write per cycle with no back-pressure beyond losing arbitration.
- last_grant updates only on an accepted handshake (valid && ready).
- Output register: on acceptance, reg_w_addr/reg_w_val load the granted addr/val and reg_w_enable <= 1. With no acceptance, reg_w_enable <= 0 and addr/val hold their previous values.
- Commit: a cycle with reg_w_enable = 1 is a commit. The regfile captures the write at the end of that cycle.
- Scoreboard:
  - rsv_ready = !busy[rsv_addr], combinational.
  - A reservation is accepted when rsv_valid && rsv_ready; busy[rsv_addr] <= 1.
  - A commit clears busy[reg_w_addr] at the same edge.
  - If a reservation and a commit hit the same address at the same edge, set wins and the bit ends at 1.
  - A commit to a non-busy register is legal and leaves busy unchanged.
  - busy is registered.
- rsv_ready is computed from registered busy only. A register being cleared this cycle still reads busy, so the decoder retries next cycle.
- Reset (reset_n low at an edge):
  - reg_w_enable = 0, reg_w_addr = 0, reg_w_val = 0, busy = 0.
  - last_grant = MEM, so the first tie goes to ALU.
  - While reset_n is low, alu_ready, mem_ready and rsv_ready are forced to 0.
  - A write accepted the cycle before reset is dropped: reg_w_enable is 0 after the reset edge.

## Timing
- Handshake at edge N puts addr/val/enable on the regfile port during cycle N+1. The regfile writes at edge N+1.
- Latency from handshake to register update: 1 cycle. A regfile read of that register returns the new value from cycle N+2.
- Back-to-back: continuous valid from both sources alternates ALU, MEM, ALU, … with reg_w_enable held high.
- busy clears at edge N+1 for a write handshaked at edge N. rsv_ready for that address rises in cycle N+2.
- No combinational path from any input to reg_w_* or busy.

## Test plan
- Reset: hold reset_n = 0 for 2 edges with alu_valid = 1 → reg_w_enable = 0, busy = 0x0000, all readies 0. Release reset → alu_ready = 1.
- Single write: alu_valid with addr = 4'h3, val = 16'd120 for one cycle → next cycle reg_w_enable = 1, addr = 3, val = 120. The cycle after, reg_w_enable = 0 and a regfile read of register 3 returns 120.
- Contention: both valid for 4 cycles (ALU addr 1, val 10; MEM addr 2, val 20) → grants ALU, MEM, ALU, MEM; reg_w_enable high for 4 consecutive cycles with matching addr/val.
- Scoreboard round trip:
  - Reserve register 5 → busy = 0x0020.
  - A second reservation of register 5 sees rsv_ready = 0.
  - mem write to addr 5 → busy = 0x0000 one edge after the commit; rsv_ready for 5 rises in the following cycle.
- Simultaneous set/clear: commit of register 7 in progress, rsv_valid for addr 7 at the same edge → busy[7] stays 1.
- Reset mid-operation: accept an ALU write to register 9, assert reset_n = 0 at the next edge → reg_w_enable = 0, register 9 unchanged, busy = 0.
